dmem_access_stage: RTL

//  Memory-access stage directly downstream of the MMU: consumes the registered data_result/data_tlb_ex
//  of a load/store, filters exceptions, drives one cached or uncached bus request with valid/ready,

---
 rtl/dmem_access_stage.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_stage.sv
// Memory-access stage after the MMU: one load/store in flight over a cached or uncached valid/ready port.
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into address-error exceptions.
module dmem_access_stage #(
    parameter int         PADDR_W  = 32,
    parameter logic [4:0] EXC_ADEL = 5'd4,
    parameter logic [4:0] EXC_ADES = 5'd5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_wdata,
    input  logic [PADDR_W-1:0] mmu_paddr,
    input  logic [31:0]        mmu_vaddr,
    input  logic               mmu_uncached,
    input  logic               mmu_illegal,
    input  logic               tlb_ex,
    input  logic [4:0]         tlb_exccode,
    input  logic               flush,
    output logic               busy,
    output logic               c_req_valid,
    output logic               uc_req_valid,
    input  logic               c_req_ready,
    input  logic               uc_req_ready,
    output logic [PADDR_W-1:0] bus_addr,
    output logic               bus_we,
    output logic [3:0]         bus_wstrb,
    output logic [31:0]        bus_wdata,
    input  logic               resp_valid,
    input  logic [31:0]        resp_rdata,
    output logic               wb_valid,
    output logic [31:0]        wb_rdata,
    output logic               ex_valid,
    output logic [4:0]         ex_code,
    output logic [31:0]        ex_badvaddr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic               uc_q, uc_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic               we_q, we_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [1:0]         off_q, off_d;
    logic               wb_valid_q, wb_valid_d;
    logic [31:0]        wb_rdata_q, wb_rdata_d;
    logic               ex_valid_q, ex_valid_d;
    logic [4:0]         ex_code_q, ex_code_d;
    logic [31:0]        ex_badvaddr_q, ex_badvaddr_d;

    logic [1:0]  eff_off;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata_lane;
    logic        misaligned;
    logic        addr_err;
    logic        sel_ready;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Misaligned offsets are truncated to the access size when not trapped.
    always_comb begin
        eff_off        = 2'b00;
        req_wstrb      = 4'hF;
        req_wdata_lane = req_wdata;
        case (req_size)
            2'd0: begin
                eff_off        = mmu_paddr[1:0];
                req_wstrb      = 4'b0001 << mmu_paddr[1:0];
                req_wdata_lane = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                eff_off        = {mmu_paddr[1], 1'b0};
                req_wstrb      = 4'b0011 << {mmu_paddr[1], 1'b0};
                req_wdata_lane = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((req_size == 2'd1) && mmu_vaddr[0]) ||
                        (req_size[1] && (mmu_vaddr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign addr_err  = misaligned || mmu_illegal;
    assign sel_ready = uc_q ? uc_req_ready : c_req_ready;

    assign shifted = resp_rdata >> {off_q, 3'b000};
    always_comb begin
        case (size_q)
            2'd0:    load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_data = resp_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        uc_d          = uc_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        signed_d      = signed_q;
        off_d         = off_q;
        wb_valid_d    = 1'b0;
        wb_rdata_d    = wb_rdata_q;
        ex_valid_d    = 1'b0;
        ex_code_d     = ex_code_q;
        ex_badvaddr_d = ex_badvaddr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    if (addr_err || tlb_ex) begin
                        ex_valid_d    = 1'b1;
                        ex_code_d     = addr_err ? (req_we ? EXC_ADES : EXC_ADEL) : tlb_exccode;
                        ex_badvaddr_d = mmu_vaddr;
                    end else begin
                        state_d  = S_REQ;
                        uc_d     = mmu_uncached;
                        addr_d   = {mmu_paddr[PADDR_W-1:2], 2'b00};
                        we_d     = req_we;
                        wstrb_d  = req_wstrb;
                        wdata_d  = req_wdata_lane;
                        size_d   = req_size;
                        signed_d = req_signed;
                        off_d    = eff_off;
                    end
                end
            end
            S_REQ: begin
                // An accepted request still owes a response, so a flush must drain it.
                if (flush)
                    state_d = sel_ready ? S_DRAIN : S_IDLE;
                else if (sel_ready)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_valid) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        wb_valid_d = 1'b1;
                        wb_rdata_d = we_q ? 32'd0 : load_data;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (resp_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            uc_q          <= 1'b0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wstrb_q       <= 4'd0;
            wdata_q       <= 32'd0;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            off_q         <= 2'd0;
            wb_valid_q    <= 1'b0;
            wb_rdata_q    <= 32'd0;
            ex_valid_q    <= 1'b0;
            ex_code_q     <= 5'd0;
            ex_badvaddr_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            uc_q          <= uc_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wstrb_q       <= wstrb_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            off_q         <= off_d;
            wb_valid_q    <= wb_valid_d;
            wb_rdata_q    <= wb_rdata_d;
            ex_valid_q    <= ex_valid_d;
            ex_code_q     <= ex_code_d;
            ex_badvaddr_q <= ex_badvaddr_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign c_req_valid  = (state_q == S_REQ) && !uc_q;
    assign uc_req_valid = (state_q == S_REQ) && uc_q;
    assign bus_addr     = addr_q;
    assign bus_we       = we_q;
    assign bus_wstrb    = wstrb_q;
    assign bus_wdata    = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rdata     = wb_rdata_q;
    assign ex_valid     = ex_valid_q;
    assign ex_code      = ex_code_q;
    assign ex_badvaddr  = ex_badvaddr_q;

endmodule
